// File: rtl/acc_sequencer.sv
// Sums one full sweep of a synchronous-read memory driven by an external address generator.
// Build option: define ACC_SATURATE_EN to clamp the accumulator instead of wrapping.
module acc_sequencer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ACC_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              addr_inc,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic              rd_valid_r;
    logic [ADDR_W-1:0] issue_cnt_r;
    logic [ACC_W-1:0]  acc_r;
    logic              ov_r;
    logic [ACC_W:0]    add_s;
    logic [ACC_W-1:0]  acc_next_s;
    logic              ov_next_s;

    // Top bit of the result flags an overflowing add; lower bits are the new accumulator.
    function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                               input logic [DATA_W-1:0] d);
        logic [ACC_W:0] full;
        full = {1'b0, a} + (ACC_W+1)'(d);
`ifdef ACC_SATURATE_EN
        if (full[ACC_W]) begin
            acc_add = {1'b1, {ACC_W{1'b1}}};
        end else begin
            acc_add = full;
        end
`else
        acc_add = full;
`endif
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_next_s = state_r;
        addr_inc     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (state_r)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if (addr != {ADDR_W{1'b0}}) begin
                        state_next_s = ALIGN;
                    end else begin
                        state_next_s = RUN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            ALIGN: begin
                addr_inc = 1'b1;
                if (addr == LAST_ADDR) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = ALIGN;
                end
            end
            RUN: begin
                addr_inc = 1'b1;
                if (issue_cnt_r == LAST_ADDR) begin
                    state_next_s = DRAIN;
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                // The final word issued in the last RUN cycle lands here.
                state_next_s = DONE;
            end
            DONE: begin
                done         = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                busy         = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // Accumulate the word returned for the address issued one cycle earlier
    always_comb begin
        add_s = acc_add(acc_r, mem_data);
        if (rd_valid_r) begin
            acc_next_s = add_s[ACC_W-1:0];
            ov_next_s  = ov_r | add_s[ACC_W];
        end else begin
            acc_next_s = acc_r;
            ov_next_s  = ov_r;
        end
    end

    // Read pipeline, accumulator and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_r  <= 1'b0;
            issue_cnt_r <= {ADDR_W{1'b0}};
            acc_r       <= {ACC_W{1'b0}};
            ov_r        <= 1'b0;
            sum         <= {ACC_W{1'b0}};
            overflow    <= 1'b0;
        end else begin
            rd_valid_r <= (state_r == RUN);
            if (state_r == IDLE) begin
                issue_cnt_r <= {ADDR_W{1'b0}};
                acc_r       <= {ACC_W{1'b0}};
                ov_r        <= 1'b0;
            end else begin
                acc_r <= acc_next_s;
                ov_r  <= ov_next_s;
                if (state_r == RUN) begin
                    issue_cnt_r <= issue_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end else begin
                    issue_cnt_r <= issue_cnt_r;
                end
            end
            // Result is published only as DONE is entered, so it includes the last word.
            if (state_r == DRAIN) begin
                sum      <= acc_next_s;
                overflow <= ov_next_s;
            end else begin
                sum      <= sum;
                overflow <= overflow;
            end
        end
    end

endmodule
